// File: rtl/serdes_pkg.sv
// -----------------------------------------------------------------------------
// serdes_pkg
// Shared constants and helpers for the serdes_link loopback SerDes.
//   DEFAULT_WIDTH : default parallel word width
//   CNT_W         : RX bit-counter width for DEFAULT_WIDTH
//   cnt_width()   : RX bit-counter width for an arbitrary word width
//   frame_len()   : serial frame length in bits (WIDTH, or WIDTH+1 when the
//                   SERDES_PARITY_EN macro appends an even-parity bit)
// -----------------------------------------------------------------------------
package serdes_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int CNT_W         = $clog2(DEFAULT_WIDTH + 2);

   function automatic int cnt_width(input int width);
      return $clog2(width + 2);
   endfunction

   function automatic int frame_len(input int width);
`ifdef SERDES_PARITY_EN
      return width + 1;
`else
      return width;
`endif
   endfunction

endpackage

// File: rtl/serdes_if.sv
// -----------------------------------------------------------------------------
// serdes_if
// Parallel/serial bus of the loopback SerDes.
//   enable     : global clock-enable, low freezes all state
//   load       : frame start, captures din
//   din        : parallel word to transmit
//   ser_dout   : serial line (TX output, looped to RX inside the link)
//   dout       : last recovered word
//   dout_valid : one-cycle pulse when dout updates
//   busy       : frame in flight
//   parity_err : received parity mismatch (only with SERDES_PARITY_EN)
// Modports: master drives enable/load/din, slave (the link) drives the rest.
// -----------------------------------------------------------------------------
interface serdes_if #(
   parameter int WIDTH = serdes_pkg::DEFAULT_WIDTH
);
   logic             enable;
   logic             load;
   logic [WIDTH-1:0] din;
   logic             ser_dout;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             busy;
`ifdef SERDES_PARITY_EN
   logic             parity_err;

   modport master (
      output enable, load, din,
      input  ser_dout, dout, dout_valid, busy, parity_err
   );
   modport slave (
      input  enable, load, din,
      output ser_dout, dout, dout_valid, busy, parity_err
   );
`else
   modport master (
      output enable, load, din,
      input  ser_dout, dout, dout_valid, busy
   );
   modport slave (
      input  enable, load, din,
      output ser_dout, dout, dout_valid, busy
   );
`endif
endinterface

// File: rtl/serdes_rx.sv
// -----------------------------------------------------------------------------
// serdes_rx
// Deserializer: collects one frame LSB-first from serial_in and presents the
// recovered word.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   enable         : clock-enable; low holds every register, masks dout_valid
//   start          : frame start (the edge that loads the transmitter)
//   serial_in      : serial line, sampled on the edges after start
//   dout           : last recovered word, held between frames
//   dout_valid     : one-cycle pulse on the cycle after the final sample
//   busy           : frame being collected
//   parity_err     : parity mismatch of the last frame (SERDES_PARITY_EN)
// -----------------------------------------------------------------------------
module serdes_rx
   import serdes_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             start,
   input  logic             serial_in,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             busy
`ifdef SERDES_PARITY_EN
   ,
   output logic             parity_err
`endif
);

   localparam int            FRAME = frame_len(WIDTH);
   localparam int            CW    = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST  = CW'(FRAME - 1);

   logic [FRAME-1:0] sr;
   logic [FRAME-1:0] word;
   logic [CW-1:0]    cnt;
   logic             armed;
   logic             valid_q;
`ifdef SERDES_PARITY_EN
   logic             perr_q;
`endif

   // New bit enters at the MSB, so after FRAME samples the first bit sits at
   // bit 0 and the original bit order is restored.
   assign word = {serial_in, sr[FRAME-1:1]};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sr      <= '0;
         cnt     <= '0;
         armed   <= 1'b0;
         valid_q <= 1'b0;
         dout    <= '0;
`ifdef SERDES_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else if (enable) begin
         valid_q <= 1'b0;
         if (armed) begin
            sr  <= word;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
               armed   <= 1'b0;
               valid_q <= 1'b1;
               dout    <= word[WIDTH-1:0];
`ifdef SERDES_PARITY_EN
               // Even parity over data plus parity bit must be 0.
               perr_q  <= ^word;
`endif
            end
         end
         // A start overrides collection: mid-frame it discards the partial
         // word; on the final edge the completion above still takes effect.
         if (start) begin
            sr    <= '0;
            cnt   <= '0;
            armed <= 1'b1;
         end
      end
   end

   // The pulse register holds while stalled; the output is masked instead.
   assign dout_valid = valid_q & enable;
   assign busy       = armed;
`ifdef SERDES_PARITY_EN
   assign parity_err = perr_q;
`endif

endmodule

// File: rtl/serdes_link.sv
// -----------------------------------------------------------------------------
// serdes_link
// Loopback SerDes: serializes a parallel word LSB-first onto ser_dout and
// recovers it through serdes_rx fed from the same line.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : serdes_if slave (enable, load, din in; ser_dout, dout,
//             dout_valid, busy and optional parity_err out)
// Optional feature macro SERDES_PARITY_EN appends an even-parity bit to each
// frame and exposes parity_err.
// -----------------------------------------------------------------------------
module serdes_link
   import serdes_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic     clock,
   input  logic     reset_n,
   serdes_if.slave  bus
);

   localparam int FRAME = frame_len(WIDTH);

   logic [FRAME-1:0] tx_sr;
   logic [FRAME-1:0] tx_frame;

   always_comb begin
      tx_frame            = '0;
      tx_frame[WIDTH-1:0] = bus.din;
`ifdef SERDES_PARITY_EN
      tx_frame[FRAME-1]   = ^bus.din;
`endif
   end

   // Zero fill makes the line idle low once the frame has drained.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tx_sr <= '0;
      end else if (bus.enable) begin
         if (bus.load) begin
            tx_sr <= tx_frame;
         end else begin
            tx_sr <= tx_sr >> 1;
         end
      end
   end

   assign bus.ser_dout = tx_sr[0];

   serdes_rx #(
      .WIDTH (WIDTH)
   ) u_rx (
      .clock      (clock),
      .reset_n    (reset_n),
      .enable     (bus.enable),
      .start      (bus.load),
      .serial_in  (tx_sr[0]),
      .dout       (bus.dout),
      .dout_valid (bus.dout_valid),
      .busy       (bus.busy)
`ifdef SERDES_PARITY_EN
      ,
      .parity_err (bus.parity_err)
`endif
   );

endmodule

// File: tb/tb_serdes_link.sv
// -----------------------------------------------------------------------------
// tb_serdes_link
// Self-checking bench for serdes_link (WIDTH=8). Reference model tracks the
// most recent load edge and its frame; every output is derived from the
// distance in enabled edges to that load.
// -----------------------------------------------------------------------------
module tb_serdes_link;
   import serdes_pkg::*;

   localparam int W = 8;
   localparam int F = frame_len(W);

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   serdes_if #(.WIDTH(W)) bus ();

   serdes_link #(.WIDTH(W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   int           edge_n;
   int           last_load;
   logic [F-1:0] last_frame;
   logic [W-1:0] m_dout;
   logic         m_valid;
   logic         m_ser;
   logic         m_busy;

   typedef struct {
      bit         en;
      bit         ld;
      logic [7:0] din;
      bit         ser;
      bit         valid;
      logic [7:0] dout;
      bit         busy;
   } vec_t;

   vec_t tbl[10];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [F-1:0] make_frame(input logic [W-1:0] d);
      logic [F-1:0] f;
      f        = '0;
      f[W-1:0] = d;
`ifdef SERDES_PARITY_EN
      f[F-1]   = ^d;
`endif
      return f;
   endfunction

   task automatic model_reset();
      edge_n     = 0;
      last_load  = -1000000;
      last_frame = '0;
      m_dout     = '0;
      m_valid    = 1'b0;
      m_ser      = 1'b0;
      m_busy     = 1'b0;
   endtask

   task automatic model_edge(input bit en, input bit ld, input logic [W-1:0] d);
      if (!en) begin
         m_valid = 1'b0;
         return;
      end
      // A frame completes exactly F enabled edges after its load, provided
      // no later load has replaced it.
      m_valid = (edge_n - last_load == F);
      if (m_valid) m_dout = last_frame[W-1:0];
      if (ld) begin
         last_load  = edge_n;
         last_frame = make_frame(d);
      end
      if (edge_n - last_load < F) begin
         m_ser  = last_frame[edge_n - last_load];
         m_busy = 1'b1;
      end else begin
         m_ser  = 1'b0;
         m_busy = 1'b0;
      end
      edge_n++;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".ser"},   32'(bus.ser_dout),   32'(m_ser));
      check({tag, ".valid"}, 32'(bus.dout_valid), 32'(m_valid));
      check({tag, ".dout"},  32'(bus.dout),       32'(m_dout));
      check({tag, ".busy"},  32'(bus.busy),       32'(m_busy));
`ifdef SERDES_PARITY_EN
      check({tag, ".perr"},  32'(bus.parity_err), 32'd0);
`endif
   endtask

   task automatic drive_edge(input bit en, input bit ld, input logic [W-1:0] d);
      bus.enable = en;
      bus.load   = ld;
      bus.din    = d;
      @(posedge clock);
      #1;
      model_edge(en, ld, d);
   endtask

   task automatic step(input bit en, input bit ld, input logic [W-1:0] d,
                       input string tag);
      drive_edge(en, ld, d);
      check_outputs(tag);
   endtask

   int pulses;

   initial begin
      bus.enable = 1'b0;
      bus.load   = 1'b0;
      bus.din    = '0;
      model_reset();
      #12;
      check("rst.ser",   32'(bus.ser_dout),   32'd0);
      check("rst.valid", 32'(bus.dout_valid), 32'd0);
      check("rst.dout",  32'(bus.dout),       32'd0);
      check("rst.busy",  32'(bus.busy),       32'd0);
      reset_n = 1'b1;
      #3;

`ifndef SERDES_PARITY_EN
      // single frame 0xA5, expected values written out by hand
      tbl[0] = '{1, 1, 8'hA5, 1, 0, 8'h00, 1};
      tbl[1] = '{1, 0, 8'h00, 0, 0, 8'h00, 1};
      tbl[2] = '{1, 0, 8'h00, 1, 0, 8'h00, 1};
      tbl[3] = '{1, 0, 8'h00, 0, 0, 8'h00, 1};
      tbl[4] = '{1, 0, 8'h00, 0, 0, 8'h00, 1};
      tbl[5] = '{1, 0, 8'h00, 1, 0, 8'h00, 1};
      tbl[6] = '{1, 0, 8'h00, 0, 0, 8'h00, 1};
      tbl[7] = '{1, 0, 8'h00, 1, 0, 8'h00, 1};
      tbl[8] = '{1, 0, 8'h00, 0, 1, 8'hA5, 0};
      tbl[9] = '{1, 0, 8'h00, 0, 0, 8'hA5, 0};
      for (int i = 0; i < 10; i++) begin
         drive_edge(tbl[i].en, tbl[i].ld, tbl[i].din);
         check($sformatf("tbl%0d.ser", i),   32'(bus.ser_dout),   32'(tbl[i].ser));
         check($sformatf("tbl%0d.valid", i), 32'(bus.dout_valid), 32'(tbl[i].valid));
         check($sformatf("tbl%0d.dout", i),  32'(bus.dout),       32'(tbl[i].dout));
         check($sformatf("tbl%0d.busy", i),  32'(bus.busy),       32'(tbl[i].busy));
      end
`else
      // parity frame 0x07: ninth bit is 1, word valid one edge later
      step(1, 1, 8'h07, "par.e0");
      for (int k = 1; k < F; k++) step(1, 0, 8'h00, "par.bit");
      check("par.bit8", 32'(bus.ser_dout), 32'd1);
      step(1, 0, 8'h00, "par.done");
      check("par.valid", 32'(bus.dout_valid), 32'd1);
      check("par.dout",  32'(bus.dout),       32'h07);
      check("par.perr",  32'(bus.parity_err), 32'd0);
      step(1, 0, 8'h00, "par.idle");
`endif

      // back-to-back frames, no idle bit
      step(1, 1, 8'h3C, "b2b.a");
      for (int k = 1; k < F; k++) step(1, 0, 8'h00, "b2b.a");
      step(1, 1, 8'hC3, "b2b.b");
      check("b2b.first_valid", 32'(bus.dout_valid), 32'd1);
      check("b2b.first_dout",  32'(bus.dout),       32'h3C);
      check("b2b.line_bit0",   32'(bus.ser_dout),   32'd1);
      for (int k = 1; k < F; k++) step(1, 0, 8'h00, "b2b.b");
      step(1, 0, 8'h00, "b2b.end");
      check("b2b.second_valid", 32'(bus.dout_valid), 32'd1);
      check("b2b.second_dout",  32'(bus.dout),       32'hC3);
      step(1, 0, 8'h00, "b2b.idle");

      // abort: 0xFF replaced at E3 by 0x12
      pulses = 0;
      step(1, 1, 8'hFF, "abort");
      for (int k = 1; k < 3; k++) step(1, 0, 8'h00, "abort");
      step(1, 1, 8'h12, "abort.reload");
      for (int k = 1; k <= F; k++) begin
         step(1, 0, 8'h00, "abort");
         if (bus.dout_valid) pulses++;
      end
      check("abort.pulses", 32'(pulses),   32'd1);
      check("abort.dout",   32'(bus.dout), 32'h12);

      // enable stall after E2
      pulses = 0;
      step(1, 1, 8'h81, "stall");
      step(1, 0, 8'h00, "stall");
      step(1, 0, 8'h00, "stall");
      for (int k = 0; k < 5; k++) begin
         step(0, 1, 8'h55, "stall.frozen");
         if (bus.dout_valid) pulses++;
      end
      for (int k = 3; k <= F; k++) begin
         step(1, 0, 8'h00, "stall");
         if (bus.dout_valid) pulses++;
      end
      check("stall.pulses", 32'(pulses),   32'd1);
      check("stall.dout",   32'(bus.dout), 32'h81);

      // reset mid-frame after E4 of 0x5A
      step(1, 1, 8'h5A, "rstmid");
      for (int k = 1; k <= 4; k++) step(1, 0, 8'h00, "rstmid");
      reset_n = 1'b0;
      #1;
      check("rstmid.ser",   32'(bus.ser_dout),   32'd0);
      check("rstmid.valid", 32'(bus.dout_valid), 32'd0);
      check("rstmid.dout",  32'(bus.dout),       32'd0);
      check("rstmid.busy",  32'(bus.busy),       32'd0);
      model_reset();
      #3;
      reset_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 2 * F; k++) begin
         step(1, 0, 8'h00, "rstmid.after");
         if (bus.dout_valid) pulses++;
      end
      check("rstmid.pulses", 32'(pulses), 32'd0);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         bit         en;
         bit         ld;
         logic [7:0] d;
         en = ($urandom_range(7) != 0);
         ld = ($urandom_range(5) == 0);
         d  = 8'($urandom);
         step(en, ld, d, $sformatf("rnd%0d", i));
      end

      bus.load = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
